uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit FIFO write port among several byte-stream requesters. It sits in front of the Tx FIFO that feeds the UART Tx datapath. It grants one requester at a time and holds the grant until that requester's record ends or a burst cap is reached, so records from different sources are not interleaved byte by byte. Transfers are gated by the global transmit enable.

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing the single Tx FIFO write port among N_REQ
//   byte-stream requesters. A grant is held until the requester's record ends
//   (req_last) or BURST_MAX bytes have been written, so records from different
//   sources are never interleaved byte by byte. Everything is gated by the
//   global transmit enable.
//
// Parameters
//   N_REQ      number of requesters (2..8)
//   BURST_MAX  maximum bytes written per grant (1..255)
//
// Ports
//   glb_clk          clock, rising edge
//   glb_rst          synchronous active-high reset
//   Cfg_ctrl_Tx_en   transmit enable; no new grant and no transfer while low
//   req_valid        per-requester byte available
//   req_data         byte of requester i on [8i+7:8i]
//   req_last         byte of requester i closes its record
//   req_ready        one-hot accept strobe for the granted requester
//   FIFO_ctrl_full   Tx FIFO full
//   FIFO_ctrl_w_en   Tx FIFO write strobe
//   FIFO_data_wdata  Tx FIFO write data
//   grant_valid      a grant is currently held
//   grant_id         index of the held or most recent grant
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 16,
  localparam int GW       = $clog2(N_REQ),
  localparam int CW       = $clog2(BURST_MAX + 1)
) (
  input  logic               glb_clk,
  input  logic               glb_rst,
  input  logic               Cfg_ctrl_Tx_en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               FIFO_ctrl_full,
  output logic               FIFO_ctrl_w_en,
  output logic [7:0]         FIFO_data_wdata,
  output logic               grant_valid,
  output logic [GW-1:0]      grant_id
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_q;
  logic [GW-1:0] grant_id_q;
  logic [GW-1:0] last_grant_q;
  logic [CW-1:0] byte_cnt_q;

  logic [GW-1:0] sel_d;
  logic [CW-1:0] cnt_d;
  logic          xfer;

  // Rotating priority: search upward from last_grant+1 with wrap-around.
  // The first hit wins; sel_d is only consumed when some req_valid is set.
  always_comb begin
    logic found;
    found = 1'b0;
    sel_d = last_grant_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant_q) + k) % N_REQ]) begin
        found = 1'b1;
        sel_d = GW'((int'(last_grant_q) + k) % N_REQ);
      end
    end
  end

  // Reset is folded in so the FIFO sees no write during a reset cycle even
  // though the state register still says XFER.
  assign xfer = (state_q == XFER) && req_valid[grant_id_q] && !FIFO_ctrl_full
                && Cfg_ctrl_Tx_en && !glb_rst;

  assign cnt_d = byte_cnt_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_id_q] = 1'b1;
  end

  assign FIFO_ctrl_w_en  = xfer;
  assign FIFO_data_wdata = req_data[8*int'(grant_id_q) +: 8];
  assign grant_valid     = (state_q == XFER);
  assign grant_id        = grant_id_q;

  // last_grant resets to N_REQ-1 so requester 0 has first priority.
  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      byte_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Cfg_ctrl_Tx_en && |req_valid) begin
            grant_id_q   <= sel_d;
            last_grant_q <= sel_d;
            byte_cnt_q   <= '0;
            state_q      <= XFER;
          end
        end
        XFER: begin
          // A dropped enable releases the grant at once; a dropped valid
          // simply stalls with the grant kept.
          if (!Cfg_ctrl_Tx_en) begin
            state_q <= IDLE;
          end else if (xfer) begin
            byte_cnt_q <= cnt_d;
            if (req_last[grant_id_q] || cnt_d == CW'(BURST_MAX)) state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, en, full;
  logic [N-1:0]   valid, last, rdy;
  logic [8*N-1:0] data;
  logic           wen, gv;
  logic [7:0]     wdata;
  logic [1:0]     gid;

  int nchk = 0;
  int nfail = 0;

  // Requester source model: byte value = 8'h10*(i+1) + running byte count.
  int seq[N], rpos[N], rlen[N], nrec[N];
  bit hold[N];

  // Outputs sampled 1 time unit after the inputs settle, away from posedge.
  logic           o_wen, o_gv;
  logic [N-1:0]   o_rdy;
  logic [7:0]     o_wdata;
  logic [1:0]     o_gid;

  uart_tx_arbiter #(.N_REQ(N), .BURST_MAX(4)) dut (
    .glb_clk(clk), .glb_rst(rst), .Cfg_ctrl_Tx_en(en),
    .req_valid(valid), .req_data(data), .req_last(last), .req_ready(rdy),
    .FIFO_ctrl_full(full), .FIFO_ctrl_w_en(wen), .FIFO_data_wdata(wdata),
    .grant_valid(gv), .grant_id(gid)
  );

  always #5 clk = ~clk;

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; rpos[i] = 0; rlen[i] = 0; nrec[i] = 0; hold[i] = 1'b0;
    end
  endtask

  task automatic setup_src(input int i, input int len, input int recs);
    rlen[i] = len; nrec[i] = recs; rpos[i] = 0; seq[i] = 0; hold[i] = 1'b0;
  endtask

  // One clock cycle: drive requester inputs, sample outputs, advance sources
  // on the accepts seen before the edge.
  task automatic tick();
    for (int i = 0; i < N; i++) begin
      valid[i]       = (nrec[i] > 0) && !hold[i];
      data[8*i +: 8] = 8'(8'h10 * (i + 1) + seq[i]);
      last[i]        = (rpos[i] == rlen[i] - 1);
    end
    #1;
    o_wen = wen; o_rdy = rdy; o_wdata = wdata; o_gv = gv; o_gid = gid;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (o_rdy[i]) begin
        seq[i]++; rpos[i]++;
        if (rpos[i] == rlen[i]) begin rpos[i] = 0; nrec[i]--; end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_src();
    rst = 1'b1; en = 1'b0; full = 1'b0;
    tick();
    tick();
    nchk++; if (o_gv !== 1'b0) begin nfail++; $display("FAIL reset_gv got=%b exp=0", o_gv); end
    nchk++; if (o_gid !== 2'd0) begin nfail++; $display("FAIL reset_gid got=%0d exp=0", o_gid); end
    nchk++; if (o_wen !== 1'b0) begin nfail++; $display("FAIL reset_wen got=%b exp=0", o_wen); end
    nchk++; if (o_rdy !== 4'b0) begin nfail++; $display("FAIL reset_rdy got=%b exp=0000", o_rdy); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] m = 32'h001DDDDC;
    logic [7:0]  exp_d[$] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31,
                              8'h32, 8'h40, 8'h41, 8'h42, 8'h13, 8'h14, 8'h15};
    int          exp_g[$] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0};
    int          w = 0;
    clear_src();
    setup_src(0, 3, 2); setup_src(1, 3, 1); setup_src(2, 3, 1); setup_src(3, 3, 1);
    en = 1'b1; full = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      nchk++; if (o_wen !== m[c]) begin nfail++; $display("FAIL rr_wen c=%0d got=%b exp=%b", c, o_wen, m[c]); end
      nchk++; if (o_gv !== m[c]) begin nfail++; $display("FAIL rr_gv c=%0d got=%b exp=%b", c, o_gv, m[c]); end
      if (m[c]) begin
        nchk++; if (o_gid !== 2'(exp_g[w]) || o_rdy !== 4'(1 << exp_g[w])) begin
          nfail++; $display("FAIL rr_grant c=%0d got=%0d/%b exp=%0d", c, o_gid, o_rdy, exp_g[w]); end
        nchk++; if (o_wdata !== exp_d[w]) begin nfail++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, o_wdata, exp_d[w]); end
        w++;
      end else begin
        nchk++; if (o_rdy !== 4'b0) begin nfail++; $display("FAIL rr_rdy c=%0d got=%b exp=0000", c, o_rdy); end
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [31:0] m = 32'h000037BC;
    int          w = 0;
    clear_src();
    setup_src(2, 10, 1);
    en = 1'b1; full = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      nchk++; if (o_wen !== m[c]) begin nfail++; $display("FAIL burst_wen c=%0d got=%b exp=%b", c, o_wen, m[c]); end
      nchk++; if (o_gv !== m[c]) begin nfail++; $display("FAIL burst_gv c=%0d got=%b exp=%b", c, o_gv, m[c]); end
      if (m[c]) begin
        nchk++; if (o_gid !== 2'd2 || o_rdy !== 4'b0100) begin
          nfail++; $display("FAIL burst_grant c=%0d got=%0d/%b exp=2/0100", c, o_gid, o_rdy); end
        nchk++; if (o_wdata !== 8'(8'h30 + w)) begin nfail++; $display("FAIL burst_data c=%0d got=%h exp=%h", c, o_wdata, 8'(8'h30 + w)); end
        w++;
      end
    end
    nchk++; if (nrec[2] !== 0 || seq[2] !== 10) begin
      nfail++; $display("FAIL burst_total got=%0d bytes recs_left=%0d exp=10/0", seq[2], nrec[2]); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] m  = 32'h0000060C;
    logic [31:0] gm = 32'h000007FC;
    int          w = 0;
    clear_src();
    setup_src(3, 4, 1);
    en = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      full = (c >= 4 && c <= 8);
      tick();
      nchk++; if (o_wen !== m[c]) begin nfail++; $display("FAIL full_wen c=%0d got=%b exp=%b", c, o_wen, m[c]); end
      nchk++; if (o_gv !== gm[c]) begin nfail++; $display("FAIL full_gv c=%0d got=%b exp=%b", c, o_gv, gm[c]); end
      if (m[c]) begin
        nchk++; if (o_gid !== 2'd3 || o_rdy !== 4'b1000) begin
          nfail++; $display("FAIL full_grant c=%0d got=%0d/%b exp=3/1000", c, o_gid, o_rdy); end
        nchk++; if (o_wdata !== 8'(8'h40 + w)) begin nfail++; $display("FAIL full_data c=%0d got=%h exp=%h", c, o_wdata, 8'(8'h40 + w)); end
        w++;
      end else begin
        nchk++; if (o_rdy !== 4'b0) begin nfail++; $display("FAIL full_rdy c=%0d got=%b exp=0000", c, o_rdy); end
      end
    end
    full = 1'b0;
  endtask

  task automatic test_tx_disable();
    logic [31:0] m  = 32'h00003B0C;
    logic [31:0] gm = 32'h00003B1C;
    logic [7:0]  exp_d[$] = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h22, 8'h23, 8'h24};
    int          exp_g[$] = '{1, 1, 2, 2, 1, 1, 1};
    int          w = 0;
    clear_src();
    setup_src(1, 5, 1); setup_src(2, 2, 1);
    full = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      en = !(c >= 4 && c <= 6);
      tick();
      nchk++; if (o_wen !== m[c]) begin nfail++; $display("FAIL txen_wen c=%0d got=%b exp=%b", c, o_wen, m[c]); end
      nchk++; if (o_gv !== gm[c]) begin nfail++; $display("FAIL txen_gv c=%0d got=%b exp=%b", c, o_gv, gm[c]); end
      if (m[c]) begin
        nchk++; if (o_gid !== 2'(exp_g[w]) || o_rdy !== 4'(1 << exp_g[w])) begin
          nfail++; $display("FAIL txen_grant c=%0d got=%0d/%b exp=%0d", c, o_gid, o_rdy, exp_g[w]); end
        nchk++; if (o_wdata !== exp_d[w]) begin nfail++; $display("FAIL txen_data c=%0d got=%h exp=%h", c, o_wdata, exp_d[w]); end
        w++;
      end else begin
        nchk++; if (o_rdy !== 4'b0) begin nfail++; $display("FAIL txen_rdy c=%0d got=%b exp=0000", c, o_rdy); end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_xfer();
    logic [31:0] m  = 32'h00000764;
    logic [31:0] gm = 32'h0000076C;
    logic [7:0]  exp_d[$] = '{8'h30, 8'h10, 8'h11, 8'h31, 8'h32, 8'h33};
    int          exp_g[$] = '{2, 0, 0, 2, 2, 2};
    int          w = 0;
    clear_src();
    setup_src(2, 4, 1); setup_src(0, 2, 1);
    en = 1'b1; full = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      rst = (c == 3);
      tick();
      nchk++; if (o_wen !== m[c]) begin nfail++; $display("FAIL rstx_wen c=%0d got=%b exp=%b", c, o_wen, m[c]); end
      nchk++; if (o_gv !== gm[c]) begin nfail++; $display("FAIL rstx_gv c=%0d got=%b exp=%b", c, o_gv, gm[c]); end
      if (c == 4) begin
        nchk++; if (o_gid !== 2'd0) begin nfail++; $display("FAIL rstx_gid c=%0d got=%0d exp=0", c, o_gid); end
      end
      if (m[c]) begin
        nchk++; if (o_gid !== 2'(exp_g[w]) || o_rdy !== 4'(1 << exp_g[w])) begin
          nfail++; $display("FAIL rstx_grant c=%0d got=%0d/%b exp=%0d", c, o_gid, o_rdy, exp_g[w]); end
        nchk++; if (o_wdata !== exp_d[w]) begin nfail++; $display("FAIL rstx_data c=%0d got=%h exp=%h", c, o_wdata, exp_d[w]); end
        w++;
      end else begin
        nchk++; if (o_rdy !== 4'b0) begin nfail++; $display("FAIL rstx_rdy c=%0d got=%b exp=0000", c, o_rdy); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_valid_gap();
    logic [31:0] m  = 32'h00000D8C;
    logic [31:0] gm = 32'h00000DFC;
    logic [7:0]  exp_d[$] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h41};
    int          exp_g[$] = '{1, 1, 1, 1, 3, 3};
    int          w = 0;
    clear_src();
    setup_src(1, 4, 1);
    en = 1'b1; full = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) setup_src(3, 2, 1);
      hold[1] = (c >= 4 && c <= 6);
      tick();
      nchk++; if (o_wen !== m[c]) begin nfail++; $display("FAIL gap_wen c=%0d got=%b exp=%b", c, o_wen, m[c]); end
      nchk++; if (o_gv !== gm[c]) begin nfail++; $display("FAIL gap_gv c=%0d got=%b exp=%b", c, o_gv, gm[c]); end
      if (c >= 4 && c <= 6) begin
        nchk++; if (o_gid !== 2'd1) begin nfail++; $display("FAIL gap_hold c=%0d got=%0d exp=1", c, o_gid); end
      end
      if (m[c]) begin
        nchk++; if (o_gid !== 2'(exp_g[w]) || o_rdy !== 4'(1 << exp_g[w])) begin
          nfail++; $display("FAIL gap_grant c=%0d got=%0d/%b exp=%0d", c, o_gid, o_rdy, exp_g[w]); end
        nchk++; if (o_wdata !== exp_d[w]) begin nfail++; $display("FAIL gap_data c=%0d got=%h exp=%h", c, o_wdata, exp_d[w]); end
        w++;
      end else begin
        nchk++; if (o_rdy !== 4'b0) begin nfail++; $display("FAIL gap_rdy c=%0d got=%b exp=0000", c, o_rdy); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; full = 1'b0;
    valid = '0; last = '0; data = '0;
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_fifo_full();
    test_tx_disable();
    test_reset_mid_xfer();
    test_valid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
